jk_bank_arbiter: RTL
====================

# jk_bank_arbiter

Two-requester arbiter and sequencer for a WIDTH-bit bank of JK flip-flops. Each requester issues a JK command (hold/clear/set/toggle) with a bit mask. The block arbitrates between the two requesters, latches the winning command, and applies it to the bank in one cycle. It acknowledges the winner with a grant pulse. The block sits between control logic and the shared JK state register and is the only writer of that register.

## Interface
- WIDTH, default 4: number of JK flip-flops in the bank (1..32).
- clk  input  1: single clock; all state updates on its rising edge.
- reset_async  input  1: asynchronous reset, active-high.
- req0, req1  input  1: request from requester 0/1; held high until the matching grant is seen.
- op0, op1  input  2: command as {J,K}. 00 = hold, 01 = clear, 10 = set, 11 = toggle.
- mask0, mask1  input  WIDTH: bits the command acts on; unmasked bits hold.
- gnt0, gnt1  output  1: high for exactly one cycle while the owner's command is being applied.
- busy  output  1: high while the FSM is in APPLY.
- q  output  WIDTH: current bank state.

## Operation
- FSM states are IDLE and APPLY.
- **IDLE:**
  - If any req is high at a clock edge, select an owner and latch that owner's op and mask.
  - Move to APPLY.
  - With no req high, stay in IDLE.
- **APPLY:**
  - Drive gnt of the owner high and busy high.
  - At the next edge, update every bit i of q as q_i <= (J_i & ~q_i) | (~K_i & q_i), where J_i = op[1] & mask[i] and K_i = op[0] & mask[i].
  - Return to IDLE.
- Arbitration when both requests are high in the same cycle:
  - Fixed priority: req0 wins (see Configuration).
  - Round-robin variant: the requester that was not the last owner wins.
- A single requester always wins, regardless of priority.
- The command is latched on entry to APPLY. Changes to req, op or mask during APPLY do not affect the command in flight.
- A request dropped during APPLY still completes and still receives its gnt pulse.
- Hold command (00) and all-zero mask are still granted; q stays unchanged.
- gnt0 and gnt1 are never high in the same cycle.
- **Reset values:** q = 0, gnt0 = gnt1 = 0, busy = 0, FSM = IDLE, last owner = requester 1 (so requester 0 is favoured first).
- **Reset mid-APPLY:** outputs clear immediately (asynchronously), the latched command is discarded, and q does not update.

## Timing
- Request latency:
  - req high before edge k → owner latched at edge k.
  - gnt high during cycle k..k+1.
  - q updated at edge k+1.
- Requester side of the handshake:
  - Sample gnt at edge k+1, then deassert req or present a new command.
  - If req is still high at edge k+1, it is ignored, because the FSM is in APPLY.
- Throughput: at most one command every 2 cycles. Back-to-back requests are re-arbitrated at edge k+2.
- Outputs gnt, busy and q are registered or decoded from registered state only, with no combinational path from inputs.
- A losing requester waits; its request stays pending and is never dropped.
- Under round-robin, the loser is granted on the next arbitration.

## Configuration
- Macro: JK_BANK_ARBITER_RR_EN.
- **Defined:** round-robin arbitration. A 1-bit last-owner register, updated on each entry to APPLY, decides ties in favour of the other requester.
- **Undefined:** fixed priority, with req0 always winning ties. The last-owner register is not built, and req1 can starve while req0 stays asserted.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** assert reset_async mid-cycle with q = 4'b1010 → q = 0, gnt0 = gnt1 = 0, busy = 0 immediately. First req0 after release → gnt0 one cycle later.
- **All four ops on requester 0** (WIDTH=4, mask0 = 4'b1111, starting from q = 0): set → 1111, toggle → 0000, set → 1111, clear → 0000, hold → 0000. Each command gets exactly one gnt0 pulse, with q updated at the edge ending that pulse.
- **Masked toggle:** q = 4'b0011, req1 with op1 = 11 and mask1 = 4'b0110 → q = 4'b0101, gnt1 for one cycle, gnt0 stays 0.
- **Simultaneous requests:** req0 and req1 held high for 8 cycles with set/clear commands.
  - With JK_BANK_ARBITER_RR_EN: grants alternate 0,1,0,1.
  - Without it: gnt0 only, gnt1 never asserted.
- **Mid-APPLY change:** during gnt0, change op0 to 01 and drop req0 → the originally latched set is applied, and the next edge finds the FSM in IDLE with no grant.
- **Reset during APPLY:** pulse reset_async while busy = 1 → q = 0, no gnt pulse completes, and the latched command is never applied after reset releases.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: two-requester JK bank sequencer; define JK_BANK_ARBITER_RR_EN for round-robin ties
module jk_bank_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_async,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask0,
  input  logic [WIDTH-1:0] mask1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] q
);
  typedef enum logic {IDLE, APPLY} state_t;
  state_t state, state_nxt;
  logic owner, win, tie, start;
  logic [1:0] op;
  logic [WIDTH-1:0] mask, j, k;
`ifdef JK_BANK_ARBITER_RR_EN
  logic last;
  assign tie = ~last;
  always_ff @(posedge clk or posedge reset_async)
    if (reset_async) last <= 1'b1;
    else if (start) last <= win;
`else
  assign tie = 1'b0;
`endif
  assign start = (state == IDLE) && (req0 || req1);
  always_comb begin
    win = (req0 && req1) ? tie : req1;
    state_nxt = (state == APPLY) ? IDLE : (start ? APPLY : IDLE);
  end
  assign j = {WIDTH{op[1]}} & mask;
  assign k = {WIDTH{op[0]}} & mask;
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      state <= IDLE;
      owner <= 1'b0;
      op    <= 2'b00;
      mask  <= '0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        owner <= win;
        op    <= win ? op1 : op0;
        mask  <= win ? mask1 : mask0;
      end
      if (state == APPLY) q <= (j & ~q) | (~k & q);
    end
  end
  assign busy = (state == APPLY);
  assign gnt0 = busy && !owner;
  assign gnt1 = busy && owner;
endmodule
